// File: rtl/seg_pkg.sv
// Shared definitions for the two-digit seven-segment scan driver:
// segment/digit widths and bit order, the blank-zero pattern, the scan
// FSM state encoding and pin-polarity helpers.
package seg_pkg;

  localparam int SEG_W = 7;
  localparam int AN_W  = 2;

  // Digit-enable bit positions on an_o.
  localparam int AN_TENS = 1;
  localparam int AN_ONES = 0;

  // Segment bit order on every 7-bit bus: {g,f,e,d,c,b,a}, a is bit 0.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  // Pattern the decoders produce for the digit 0 (a..f lit, g dark).
  localparam logic [SEG_W-1:0] SEG_ZERO = 7'h3F;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BLANK_T = 3'd1,
    SHOW_T  = 3'd2,
    BLANK_O = 3'd3,
    SHOW_O  = 3'd4
  } scan_state_t;

  // Segment bus value with every segment dark at pin polarity.
  function automatic logic [SEG_W-1:0] seg_off(input bit active_low);
    return active_low ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  endfunction

  // Digit-enable value with both digits disabled at pin polarity.
  function automatic logic [AN_W-1:0] an_off(input bit active_low);
    return active_low ? {AN_W{1'b1}} : {AN_W{1'b0}};
  endfunction

endpackage

// File: rtl/seg_scan_driver_if.sv
// Display-side bundle of the scan driver: enable and the two active-high
// digit patterns in, the multiplexed pin-level segment bus, digit enables
// and frame strobe out, plus the FSM state for observation.
// There is no handshake: inputs are level signals sampled once per frame,
// outputs are registered levels valid every cycle after reset.
interface seg_scan_driver_if;
  import seg_pkg::*;

  logic                en_i;
  logic [SEG_W-1:0]    seg_tens_i;
  logic [SEG_W-1:0]    seg_ones_i;
  logic [SEG_W-1:0]    seg_o;
  logic [AN_W-1:0]     an_o;
  logic                frame_o;
  scan_state_t         state_dbg;

  // Source of the digit patterns / consumer of the pin signals.
  modport master (
    output en_i, seg_tens_i, seg_ones_i,
    input  seg_o, an_o, frame_o, state_dbg
  );

  // The scan driver itself.
  modport slave (
    input  en_i, seg_tens_i, seg_ones_i,
    output seg_o, an_o, frame_o, state_dbg
  );

endinterface

// File: rtl/scan_slot_timer.sv
// Slot counter shared by all active scan states. Counts 0..SLOT_CYCLES-1
// and wraps; clear forces it back to 0 (used while idle and on frame start).
// blank_end marks the last dead-time cycle of a slot, slot_end the last
// cycle of the slot.
module scan_slot_timer #(
  parameter int SLOT_CYCLES  = 125000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic blank_end,
  output logic slot_end
);

  localparam int CW = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;

  logic [CW-1:0] cnt;

  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt == CW'(SLOT_CYCLES - 1));

  // Free-running slot count with synchronous clear and wrap at slot end.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (slot_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Two-digit seven-segment scan driver. Snapshots the tens and ones patterns
// at the start of every frame, then shows tens and ones in alternating
// slots on a shared segment bus, each slot opening with a dead-time blank
// so the previous digit cannot ghost onto the next one.
// Optional build macro: SEG_SCAN_LEADING_ZERO_BLANK_EN -- when defined, a
// tens snapshot equal to the zero pattern is kept dark during its slot.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int CLK_HZ       = 125000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_driver_if.slave   disp
);

  localparam int SLOT_CYCLES = CLK_HZ / SCAN_HZ;

  localparam logic [SEG_W-1:0] SEG_OFF = seg_off(ACTIVE_LOW != 0);
  localparam logic [AN_W-1:0]  AN_OFF  = an_off(ACTIVE_LOW != 0);
  // Pin-level digit enables with exactly one digit on.
  localparam logic [AN_W-1:0]  AN_TENS_ON = AN_OFF ^ (AN_W'(1) << AN_TENS);
  localparam logic [AN_W-1:0]  AN_ONES_ON = AN_OFF ^ (AN_W'(1) << AN_ONES);

  // Reject timing parameters that cannot produce a blank plus a visible part.
  if (SLOT_CYCLES < 2) begin : g_bad_slot
    $error("seg_scan_driver: CLK_HZ/SCAN_HZ must be at least 2");
  end
  if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT_CYCLES - 1) begin : g_bad_blank
    $error("seg_scan_driver: BLANK_CYCLES must be in 1..SLOT_CYCLES-1");
  end

  scan_state_t       state;
  logic [SEG_W-1:0]  snap_t;
  logic [SEG_W-1:0]  snap_o;
  logic [SEG_W-1:0]  seg_q;
  logic [AN_W-1:0]   an_q;
  logic              frame_q;
  logic              blank_end;
  logic              slot_end;
  logic              timer_clear;
  logic              show_tens;

  // Counter restarts whenever the scan is idle or being shut off; on a frame
  // wrap from SHOW_O it returns to 0 on its own.
  assign timer_clear = (state == IDLE) || !disp.en_i;

  scan_slot_timer #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (timer_clear),
    .blank_end (blank_end),
    .slot_end  (slot_end)
  );

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  assign show_tens = (snap_t != SEG_ZERO);
`else
  assign show_tens = 1'b1;
`endif

  // Scan FSM with registered pin outputs; outputs are computed for the state
  // being entered so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap_t  <= '0;
      snap_o  <= '0;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else if (!disp.en_i) begin
      state   <= IDLE;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      case (state)
        IDLE: begin
          state   <= BLANK_T;
          snap_t  <= disp.seg_tens_i;
          snap_o  <= disp.seg_ones_i;
          frame_q <= 1'b1;
          seg_q   <= SEG_OFF;
          an_q    <= AN_OFF;
        end
        BLANK_T: begin
          if (blank_end) begin
            state <= SHOW_T;
            if (show_tens) begin
              seg_q <= snap_t ^ SEG_OFF;
              an_q  <= AN_TENS_ON;
            end else begin
              seg_q <= SEG_OFF;
              an_q  <= AN_OFF;
            end
          end
        end
        SHOW_T: begin
          if (slot_end) begin
            state <= BLANK_O;
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
          end
        end
        BLANK_O: begin
          if (blank_end) begin
            state <= SHOW_O;
            seg_q <= snap_o ^ SEG_OFF;
            an_q  <= AN_ONES_ON;
          end
        end
        SHOW_O: begin
          if (slot_end) begin
            state   <= BLANK_T;
            snap_t  <= disp.seg_tens_i;
            snap_o  <= disp.seg_ones_i;
            frame_q <= 1'b1;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
          end
        end
        default: begin
          state <= IDLE;
          seg_q <= SEG_OFF;
          an_q  <= AN_OFF;
        end
      endcase
    end
  end

  assign disp.seg_o     = seg_q;
  assign disp.an_o      = an_q;
  assign disp.frame_o   = frame_q;
  assign disp.state_dbg = state;

endmodule
